// File: rtl/btn_deb_multi.sv
// rtl/btn_deb_multi.sv - multi-channel button debouncer with press/release/auto-repeat pulses
//
// Purpose: synchronise N_CH raw push-button inputs, qualify every change against
// a stable-time counter, and emit per-channel debounced level plus one-cycle
// press, release and auto-repeat pulses.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous active-low reset
//   w          in   N_CH  raw asynchronous button inputs, active-high
//   z          out  N_CH  debounced level
//   press      out  N_CH  one-cycle pulse on debounced 0->1
//   rel        out  N_CH  one-cycle pulse on debounced 1->0 ("release" is a
//                         reserved word in SystemVerilog)
//   rpt        out  N_CH  one-cycle auto-repeat pulse while held
//   any_press  out  1     OR of press, combinational
module btn_deb_multi #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_RATE   = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] w,
  output logic [N_CH-1:0] z,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt,
  output logic            any_press
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_RATE - 1);

  // Bit 1 of the encoding is the debounced level, so z is a plain flop output.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    QUAL_HIGH = 2'b01,
    HIGH      = 2'b10,
    QUAL_LOW  = 2'b11
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_expire;
    logic                   w_rise;
    logic                   w_fall;
    logic                   r_press;
    logic                   r_rel;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w[i]};
      end
    end

    assign w_s      = r_sync[SYNC_STAGES-1];
    // Last qualifying cycle: the level flips on this edge.
    assign w_expire = (w_s != r_state[1]) && (r_cnt == C_LAST);
    assign w_rise   = w_expire && !r_state[1];
    assign w_fall   = w_expire && r_state[1];

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
        LOW, QUAL_HIGH: begin
          if (!w_s) begin
            w_state_nxt = LOW;
          end else if (w_expire) begin
            w_state_nxt = HIGH;
          end else begin
            w_state_nxt = QUAL_HIGH;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        HIGH, QUAL_LOW: begin
          if (w_s) begin
            w_state_nxt = HIGH;
          end else if (w_expire) begin
            w_state_nxt = LOW;
          end else begin
            w_state_nxt = QUAL_LOW;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = LOW;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= LOW;
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_press <= w_rise;
        r_rel   <= w_fall;
      end
    end

    assign z[i]     = r_state[1];
    assign press[i] = r_press;
    assign rel[i]   = r_rel;

    if (REPEAT_EN != 0) begin : g_rpt
      logic [RW-1:0] r_rcnt;
      logic          r_rphase;
      logic          r_rpt;

      // While z is low (including the press edge itself) the counter is held
      // at zero, so counting starts on the edge after press. r_rphase selects
      // the initial delay versus the steady repeat interval.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b0;
          r_rpt    <= 1'b0;
        end else if (!r_state[1] || w_fall) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b0;
          r_rpt    <= 1'b0;
        end else if (r_rcnt == (r_rphase ? R_NEXT : R_FIRST)) begin
          r_rcnt   <= '0;
          r_rphase <= 1'b1;
          r_rpt    <= 1'b1;
        end else begin
          r_rcnt   <= r_rcnt + 1'b1;
          r_rpt    <= 1'b0;
        end
      end

      assign rpt[i] = r_rpt;
    end else begin : g_norpt
      assign rpt[i] = 1'b0;
    end
  end

  assign any_press = |press;

endmodule

// File: tb/tb_btn_deb_multi.sv
// tb/tb_btn_deb_multi.sv - scoreboard bench for btn_deb_multi
module tb_btn_deb_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] w;
  logic [1:0] z, press, rel, rpt;
  logic       any_press;
  logic [1:0] n_z, n_press, n_rel, n_rpt;
  logic       n_any;

  btn_deb_multi #(
    .N_CH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .w(w), .z(z), .press(press), .rel(rel),
    .rpt(rpt), .any_press(any_press)
  );

  btn_deb_multi #(
    .N_CH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut_norpt (
    .clk(clk), .rst(rst), .w(w), .z(n_z), .press(n_press), .rel(n_rel),
    .rpt(n_rpt), .any_press(n_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] rpt;
    logic [1:0] z;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] t, input logic [1:0] zz);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = t; e.z = zz;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      chk("reset_outputs_zero",
          {z, press, rel, rpt, any_press, n_z, n_press, n_rel, n_rpt, n_any}, 32'd0);
    end else begin
      chk("norpt_build_rpt", {30'd0, n_rpt}, 32'd0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("press",        {30'd0, press},   {30'd0, e.press});
        chk("release",      {30'd0, rel},     {30'd0, e.rel});
        chk("rpt",          {30'd0, rpt},     {30'd0, e.rpt});
        chk("z",            {30'd0, z},       {30'd0, e.z});
        chk("any_press",    {31'd0, any_press}, {31'd0, |e.press});
        chk("norpt_press",  {30'd0, n_press}, {30'd0, e.press});
        chk("norpt_release",{30'd0, n_rel},   {30'd0, e.rel});
        chk("norpt_z",      {30'd0, n_z},     {30'd0, e.z});
      end else if ((press | rel | rpt | n_press | n_rel) != 2'b00 || any_press) begin
        chk("unexpected_pulse", {23'd0, any_press, press, rel, rpt, n_press, n_rel}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int p;
    rst = 1'b0;
    w   = 2'b00;

    // Reset held: random input activity must not reach any output.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      w = 2'($urandom_range(0, 3));
    end
    @(negedge clk); w = 2'b00;
    @(negedge clk); w = 2'b00;
    @(negedge clk); rst = 1'b1;
    repeat (6) @(negedge clk);

    // Clean press on channel 0, then release well before the first repeat.
    k = cyc; w = 2'b01;
    push(k + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(k + 8); w = 2'b00;
    push(k + 14, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(k + 30);

    // Bounce: 3 high, 1 low, then steady high.
    k = cyc; w = 2'b01;
    wait_until(k + 3); w = 2'b00;
    wait_until(k + 4); w = 2'b01;
    push(k + 10, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(k + 12); w = 2'b00;
    push(k + 18, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(k + 35);

    // Auto-repeat on channel 1; release lands before the fourth repeat.
    k = cyc; p = k + 6; w = 2'b10;
    push(p,      2'b10, 2'b00, 2'b00, 2'b10);
    push(p + 10, 2'b00, 2'b00, 2'b10, 2'b10);
    push(p + 13, 2'b00, 2'b00, 2'b10, 2'b10);
    push(p + 16, 2'b00, 2'b00, 2'b10, 2'b10);
    wait_until(p + 12); w = 2'b00;
    push(p + 18, 2'b00, 2'b10, 2'b00, 2'b00);
    wait_until(p + 40);

    // Simultaneous press on both channels, held 50 cycles.
    k = cyc; p = k + 6; w = 2'b11;
    push(p, 2'b11, 2'b00, 2'b00, 2'b11);
    for (int j = 0; j < 14; j++) push(p + 10 + 3 * j, 2'b00, 2'b00, 2'b11, 2'b11);
    wait_until(k + 50); w = 2'b00;
    push(k + 56, 2'b00, 2'b11, 2'b00, 2'b00);
    wait_until(k + 75);

    // Asynchronous reset while HIGH, with the button held through reset release.
    k = cyc; w = 2'b01;
    push(k + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(k + 8);
    chk("pre_reset_z", {30'd0, z}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset_z", {28'd0, z, n_z}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    k = cyc; rst = 1'b1;
    push(k + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    wait_until(k + 8); w = 2'b00;
    push(k + 14, 2'b00, 2'b01, 2'b00, 2'b00);
    wait_until(k + 30);

    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/btn_deb_multi.md
Name: btn_deb_multi

Overview:
Parametrised, multi-channel successor to the single-button debouncer. It synchronises N raw button inputs and qualifies each against a programmable stable-time counter, replacing the fixed 3-sample AND. Per channel it produces the debounced level, one-cycle press and release pulses, and an optional auto-repeat pulse train. It sits between the board push-buttons and the calculator input/keypad logic.

Parameters:
N_CH, 5, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
STABLE_CYCLES, 1000000, consecutive cycles the synchronised input must differ from the current level before the level flips (>=1; 10 ms at 100 MHz)
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = rpt tied low and repeat counters removed
REPEAT_DELAY, 50000000, cycles from the press pulse to the first rpt pulse (>=1)
REPEAT_RATE, 10000000, cycles between subsequent rpt pulses (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
w  in  N_CH  raw, asynchronous button inputs, active-high
z  out  N_CH  debounced level per channel
press  out  N_CH  one-cycle pulse on each debounced 0->1 transition
release  out  N_CH  one-cycle pulse on each debounced 1->0 transition
rpt  out  N_CH  one-cycle auto-repeat pulse while held
any_press  out  1  OR-reduction of press

Behaviour:
- Reset: rst low clears all synchroniser flops, z, press, release, rpt, any_press, and all counters to 0 immediately, independent of clk. The outputs stay 0 until the first qualified change after rst rises.
- Synchroniser: w[i] passes through a shift chain of SYNC_STAGES flops; s[i] is the last stage. No logic sits between the stages.
- Stable counter: each channel has a counter of width clog2(STABLE_CYCLES+1).
  - If s != z, the counter increments each cycle.
  - When s != z and the counter equals STABLE_CYCLES-1, the channel sets z <= s, clears the counter, and pulses press (rising) or release (falling) on the same edge.
  - If s == z, the counter clears to 0. Any bounce therefore restarts qualification.
- Latency: let edge 0 be the first clk edge that samples a new, steady w. z flips, and press or release asserts, at edge SYNC_STAGES+STABLE_CYCLES-1. The pulse is high for exactly one cycle.
- Per-channel FSM: states LOW, QUAL_HIGH, HIGH, QUAL_LOW.
  - LOW -> QUAL_HIGH when s=1.
  - QUAL_HIGH -> LOW when s=0.
  - QUAL_HIGH -> HIGH on count expiry, with a press pulse.
  - HIGH and QUAL_LOW mirror this; QUAL_LOW -> LOW on expiry, with a release pulse.
  - z=1 in HIGH and QUAL_LOW.
- Auto-repeat (REPEAT_EN=1): the repeat counter clears on the press edge and counts while z=1.
  - First rpt pulse comes REPEAT_DELAY cycles after press, then every REPEAT_RATE cycles.
  - For press at edge P, rpt is at edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_RATE, and so on.
  - rpt never coincides with press.
  - The repeat counter clears and rpt is suppressed from the edge where z falls. While in QUAL_LOW, z is still 1, so repeats continue.
- Channels are fully independent. Simultaneous qualification on several channels asserts all of their pulses in the same cycle.
- any_press is combinational OR of press; it adds no extra latency.
- A button held high through reset release is reported as a normal press after the standard latency.
- Counters saturate by construction; wrap-around cannot occur.

Test Plan:
(Test parameters: N_CH=2, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_EN=1)
1. Reset: hold rst=0, toggle w randomly for 20 cycles -> all outputs 0 throughout. Assert rst=0 mid-HIGH -> z[0] drops to 0 before the next clk edge.
2. Clean press: w[0] 0->1 steady from edge 0 -> z[0] rises and press[0]=1 at edge 5 only; any_press=1 that cycle; channel 1 stays 0.
3. Bounce: w[0]=1 for 3 cycles, 0 for 1 cycle, then steady 1 -> no press during the bounce; press occurs exactly 5 edges after the final rise.
4. Release: after a press, w[0] 1->0 steady from edge R -> z[0] falls and release[0]=1 at edge R+5; no rpt afterwards.
5. Auto-repeat: hold w[1]=1, press at edge P -> rpt[1] at P+10, P+13, P+16; release before P+19 -> no further rpt.
6. Simultaneous, plus REPEAT_EN=0 build: w[0] and w[1] rise on the same edge -> both press bits assert in the same cycle. With REPEAT_EN=0, hold 50 cycles -> rpt stays 0.
